mac_dsp_pipe: RTL and testbench

Parametrised, pipelined multiply-accumulate unit intended to map onto one DSP slice. It generalises the team's registered-operand multiplier with the following additions:
- configurable product pipeline depth
- per-sample signed/unsigned mode
- a running accumulator with per-sample restart
- optional saturation
- valid/ready flow control

It sits between a streaming sample source and downstream filter/accumulate logic.

---
 rtl/mac_dsp_pipe.sv | 169 ++++++++++++++++
 tb/tb_mac_dsp_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dsp_pipe.sv
// Pipelined multiply-accumulate for a single DSP slice: operand register, PIPE_STAGES
// product registers, then a saturating/wrapping accumulator with valid/ready handshake.
module mac_dsp_pipe #(
  parameter int A_WIDTH     = 25,
  parameter int B_WIDTH     = 18,
  parameter int ACC_WIDTH   = 48,
  parameter int PIPE_STAGES = 2,
  parameter int SATURATE    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  input  logic                 signed_i,
  input  logic                 first_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ACC_WIDTH-1:0] res_o,
  output logic                 ovf_o
);

  localparam int PW   = A_WIDTH + B_WIDTH + 2;
  localparam int LAST = PIPE_STAGES - 1;

  if (ACC_WIDTH < A_WIDTH + B_WIDTH) begin : g_chk_acc
    $error("mac_dsp_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end
  if (PIPE_STAGES < 1) begin : g_chk_pipe
    $error("mac_dsp_pipe: PIPE_STAGES must be >= 1");
  end

  logic                 adv;

  logic                 vld0_q, vld0_d;
  logic [A_WIDTH-1:0]   a_q, a_d;
  logic [B_WIDTH-1:0]   b_q, b_d;
  logic                 sgn0_q, sgn0_d;
  logic                 first0_q, first0_d;

  logic [ACC_WIDTH-1:0] prod_q [PIPE_STAGES];
  logic [ACC_WIDTH-1:0] prod_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] pvld_q, pvld_d;
  logic [PIPE_STAGES-1:0] psgn_q, psgn_d;
  logic [PIPE_STAGES-1:0] pfirst_q, pfirst_d;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 vout_q, vout_d;
  logic                 seen_q, seen_d;

  logic [PW-1:0]        a_w, b_w, prod_full;
  logic [ACC_WIDTH-1:0] prod_acc;

  logic                 fsgn, ffirst, ovf_nxt;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_nxt;

  assign adv     = ~vout_q | ready_i;
  assign ready_o = adv;
  assign valid_o = vout_q;
  assign res_o   = acc_q;
  assign ovf_o   = ovf_q;

  // Operands are extended by mode to the full product width, so one multiplier serves both modes.
  always_comb begin
    a_w       = {{(PW-A_WIDTH){sgn0_q & a_q[A_WIDTH-1]}}, a_q};
    b_w       = {{(PW-B_WIDTH){sgn0_q & b_q[B_WIDTH-1]}}, b_q};
    prod_full = a_w * b_w;
  end

  if (ACC_WIDTH > PW) begin : g_prod_ext
    assign prod_acc = {{(ACC_WIDTH-PW){prod_full[PW-1]}}, prod_full};
  end else begin : g_prod_trunc
    assign prod_acc = prod_full[ACC_WIDTH-1:0];
  end

  always_comb begin
    fsgn    = psgn_q[LAST];
    ffirst  = pfirst_q[LAST] | ~seen_q;
    sum     = {fsgn & acc_q[ACC_WIDTH-1], acc_q}
            + {fsgn & prod_q[LAST][ACC_WIDTH-1], prod_q[LAST]};
    ovf_nxt = 1'b0;
    acc_nxt = sum[ACC_WIDTH-1:0];
    if (ffirst) begin
      acc_nxt = prod_q[LAST];
    end else begin
      ovf_nxt = fsgn ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
      if (ovf_nxt && (SATURATE != 0)) begin
        if (!fsgn)               acc_nxt = '1;
        else if (sum[ACC_WIDTH]) acc_nxt = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else                     acc_nxt = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end

  always_comb begin
    vld0_d   = vld0_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn0_d   = sgn0_q;
    first0_d = first0_q;
    prod_d   = prod_q;
    pvld_d   = pvld_q;
    psgn_d   = psgn_q;
    pfirst_d = pfirst_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    vout_d   = vout_q;
    seen_d   = seen_q;
    if (adv) begin
      vld0_d      = valid_i;
      a_d         = a_i;
      b_d         = b_i;
      sgn0_d      = signed_i;
      first0_d    = first_i;
      prod_d[0]   = prod_acc;
      pvld_d[0]   = vld0_q;
      psgn_d[0]   = sgn0_q;
      pfirst_d[0] = first0_q;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        prod_d[i]   = prod_q[i-1];
        pvld_d[i]   = pvld_q[i-1];
        psgn_d[i]   = psgn_q[i-1];
        pfirst_d[i] = pfirst_q[i-1];
      end
      vout_d = pvld_q[LAST];
      if (pvld_q[LAST]) begin
        acc_d  = acc_nxt;
        ovf_d  = ovf_nxt;
        seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld0_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sgn0_q   <= 1'b0;
      first0_q <= 1'b0;
      for (int unsigned i = 0; i < PIPE_STAGES; i++) prod_q[i] <= '0;
      pvld_q   <= '0;
      psgn_q   <= '0;
      pfirst_q <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      vout_q   <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      vld0_q   <= vld0_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn0_q   <= sgn0_d;
      first0_q <= first0_d;
      prod_q   <= prod_d;
      pvld_q   <= pvld_d;
      psgn_q   <= psgn_d;
      pfirst_q <= pfirst_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      vout_q   <= vout_d;
      seen_q   <= seen_d;
    end
  end

endmodule

// File: tb/tb_mac_dsp_pipe.sv
// Directed bench for mac_dsp_pipe: default instance plus two 43-bit instances
// (saturating and wrapping) that share the same stimulus.
module tb_mac_dsp_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [24:0] a_i;
  logic [17:0] b_i;
  logic        signed_i;
  logic        first_i;
  logic        ready_i;

  logic        ready_o, valid_o, ovf_o;
  logic [47:0] res_o;
  logic        s_ready, s_valid, s_ovf;
  logic [42:0] s_res;
  logic        w_ready, w_valid, w_ovf;
  logic [42:0] w_res;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mac_dsp_pipe u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .first_i(first_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .ovf_o(ovf_o)
  );

  mac_dsp_pipe #(.ACC_WIDTH(43), .SATURATE(1)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(s_ready),
    .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .first_i(first_i),
    .valid_o(s_valid), .ready_i(ready_i), .res_o(s_res), .ovf_o(s_ovf)
  );

  mac_dsp_pipe #(.ACC_WIDTH(43), .SATURATE(0)) u_wrap (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(w_ready),
    .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .first_i(first_i),
    .valid_o(w_valid), .ready_i(ready_i), .res_o(w_res), .ovf_o(w_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [24:0] a, input logic [17:0] b,
                       input logic s, input logic f);
    valid_i  = v;
    a_i      = a;
    b_i      = b;
    signed_i = s;
    first_i  = f;
  endtask

  int          bp_exp [5] = '{1, 3, 6, 10, 15};
  int          idx, nout;
  logic        stalled, accept;
  logic [47:0] held;

  initial begin
    rst_i   = 1'b0;
    ready_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_res",   64'(res_o),   64'(0));
    chk("rst_ovf",   64'(ovf_o),   64'(0));
    tick();
    rst_i = 1'b1;
    #1;
    chk("rst_ready", 64'(ready_o), 64'(1));

    // 1: single signed sample 3 * -5
    drive(1'b1, 25'd3, 18'h3FFFB, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("t1_lat1", 64'(valid_o), 64'(0));
    tick();
    chk("t1_lat2", 64'(valid_o), 64'(0));
    tick();
    chk("t1_valid", 64'(valid_o), 64'(1));
    chk("t1_res",   64'(res_o),   64'(48'hFFFF_FFFF_FFF1));
    chk("t1_ovf",   64'(ovf_o),   64'(0));
    tick();
    chk("t1_pulse", 64'(valid_o), 64'(0));

    // 2: back-to-back signed stream, then restart
    drive(1'b1, 25'd2, 18'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 25'd4, 18'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 25'h1FF_FFFF, 18'd6, 1'b1, 1'b0);
    tick();
    drive(1'b1, 25'd7, 18'd7, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_v0", 64'(valid_o), 64'(1));
    chk("t2_r0", 64'(res_o),   64'(6));
    tick();
    chk("t2_v1", 64'(valid_o), 64'(1));
    chk("t2_r1", 64'(res_o),   64'(26));
    tick();
    chk("t2_v2", 64'(valid_o), 64'(1));
    chk("t2_r2", 64'(res_o),   64'(20));
    tick();
    chk("t2_v3", 64'(valid_o), 64'(1));
    chk("t2_r3", 64'(res_o),   64'(49));
    tick();
    chk("t2_idle", 64'(valid_o), 64'(0));

    // 3: unsigned full-scale product, no sign extension
    drive(1'b1, 25'h1FF_FFFF, 18'h3FFFF, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("t3_valid", 64'(valid_o), 64'(1));
    chk("t3_res",   64'(res_o),   64'(48'h07FF_FDFC_0001));
    chk("t3_ovf",   64'(ovf_o),   64'(0));
    tick();

    // 4: backpressure on cycles 4..6, five samples 1*k
    idx     = 0;
    nout    = 0;
    stalled = 1'b0;
    held    = '0;
    for (int c = 0; c < 40 && nout < 5; c++) begin
      ready_i = !(c >= 4 && c <= 6);
      drive(idx < 5, 25'd1, 18'(idx + 1), 1'b1, idx == 0);
      #1;
      if (stalled) begin
        chk("t4_hold_res",   64'(res_o),   64'(held));
        chk("t4_hold_valid", 64'(valid_o), 64'(1));
      end
      if (valid_o && !ready_i) begin
        chk("t4_ready_low", 64'(ready_o), 64'(0));
        stalled = 1'b1;
        held    = res_o;
      end else begin
        stalled = 1'b0;
      end
      if (valid_o && ready_i) begin
        chk("t4_res", 64'(res_o), 64'(bp_exp[nout]));
        nout++;
      end
      accept = valid_i && ready_o;
      tick();
      if (accept) idx++;
    end
    chk("t4_count", 64'(nout), 64'(5));
    ready_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();

    // 5a: signed overflow, (-2^24)*(-2^17) accumulated twice
    drive(1'b1, 25'h100_0000, 18'h20000, 1'b1, 1'b1);
    tick();
    drive(1'b1, 25'h100_0000, 18'h20000, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    tick();
    chk("t5_sat_r0",  64'(s_res), 64'(43'h200_0000_0000));
    chk("t5_sat_o0",  64'(s_ovf), 64'(0));
    chk("t5_wrap_r0", 64'(w_res), 64'(43'h200_0000_0000));
    tick();
    chk("t5_sat_v1",  64'(s_valid), 64'(1));
    chk("t5_sat_r1",  64'(s_res),   64'(43'h3FF_FFFF_FFFF));
    chk("t5_sat_o1",  64'(s_ovf),   64'(1));
    chk("t5_wrap_r1", 64'(w_res),   64'(43'h400_0000_0000));
    chk("t5_wrap_o1", 64'(w_ovf),   64'(1));
    chk("t5_wide_r1", 64'(res_o),   64'(48'h0400_0000_0000));
    chk("t5_wide_o1", 64'(ovf_o),   64'(0));
    tick();

    // 5b: unsigned overflow, full-scale product accumulated twice
    drive(1'b1, 25'h1FF_FFFF, 18'h3FFFF, 1'b0, 1'b1);
    tick();
    drive(1'b1, 25'h1FF_FFFF, 18'h3FFFF, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("t5u_sat_r",  64'(s_res), 64'(43'h7FF_FFFF_FFFF));
    chk("t5u_sat_o",  64'(s_ovf), 64'(1));
    chk("t5u_wrap_r", 64'(w_res), 64'(43'h7FF_FBF8_0002));
    chk("t5u_wrap_o", 64'(w_ovf), 64'(1));
    chk("t5u_wide_r", 64'(res_o), 64'(48'h0FFF_FBF8_0002));
    chk("t5u_wide_o", 64'(ovf_o), 64'(0));
    tick();

    // 6: asynchronous reset with samples in flight
    drive(1'b1, 25'd2, 18'd2, 1'b1, 1'b1);
    tick();
    drive(1'b1, 25'd5, 18'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 25'd1, 18'd1, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("t6_pre_valid", 64'(valid_o), 64'(1));
    chk("t6_pre_res",   64'(res_o),   64'(4));
    #2;
    rst_i = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(valid_o), 64'(0));
    chk("t6_rst_res",   64'(res_o),   64'(0));
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_no_stale", 64'(valid_o), 64'(0));
    end
    drive(1'b1, 25'd3, 18'd4, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    chk("t6_after_valid", 64'(valid_o), 64'(1));
    chk("t6_after_res",   64'(res_o),   64'(12));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
